// File: rtl/picosoc_iomem_router_if.sv
// PicoRV32 iomem bus bundle: CPU-side request/response plus the broadcast slave channels.
// The router takes the slave modport; the CPU/peripheral environment takes the master modport.
interface picosoc_iomem_router_if #(
    parameter int unsigned NUM_SLAVES = 8
) ();
    logic                      iomem_valid;
    logic                      iomem_instr;
    logic [3:0]                iomem_wstrb;
    logic [31:0]               iomem_addr;
    logic [31:0]               iomem_wdata;
    logic                      iomem_ready;
    logic [31:0]               iomem_rdata;

    logic [NUM_SLAVES-1:0]     s_valid;
    logic                      s_instr;
    logic [3:0]                s_wstrb;
    logic [31:0]               s_addr;
    logic [31:0]               s_wdata;
    logic [NUM_SLAVES-1:0]     s_ready;
    logic [NUM_SLAVES*32-1:0]  s_rdata;

    modport slave (
        input  iomem_valid, iomem_instr, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata,
        output s_valid, s_instr, s_wstrb, s_addr, s_wdata,
        input  s_ready, s_rdata
    );

    modport master (
        output iomem_valid, iomem_instr, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata,
        input  s_valid, s_instr, s_wstrb, s_addr, s_wdata,
        output s_ready, s_rdata
    );
endinterface

// File: rtl/picosoc_iomem_router.sv
// Page-decoded iomem interconnect: routes each request to one slave, registers the response,
// and error-terminates unmapped (and, with PICOSOC_IOMEM_TIMEOUT_EN defined, stalled) accesses.
module picosoc_iomem_router #(
    parameter int unsigned              NUM_SLAVES     = 8,
    parameter logic [NUM_SLAVES*8-1:0]  SLAVE_PAGE     = {8'h00, 8'h02, 8'h03, 8'h04,
                                                          8'h05, 8'h06, 8'h07, 8'h08},
    parameter int unsigned              TIMEOUT_CYCLES = 1023,
    parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                          clk,
    input  logic                          reset,
    picosoc_iomem_router_if.slave         bus,
    output logic                          err_o,
    output logic [1:0]                    err_code_o,
    output logic [31:0]                   err_addr_o,
    output logic [7:0]                    err_count_o
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("picosoc_iomem_router: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_e;

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [NUM_SLAVES-1:0]  s_valid_q, s_valid_d;
    logic                   s_instr_q, s_instr_d;
    logic [3:0]             s_wstrb_q, s_wstrb_d;
    logic [31:0]            s_addr_q, s_addr_d;
    logic [31:0]            s_wdata_q, s_wdata_d;
    logic                   ready_q, ready_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [31:0]            err_addr_q, err_addr_d;
    logic [7:0]             err_count_q, err_count_d;

    logic                   hit_c;
    logic [SEL_W-1:0]       hit_idx_c;
    logic                   sel_ready_c;
    logic [31:0]            sel_rdata_c;
    logic                   to_hit_c;
    logic [7:0]             err_count_inc_c;

    // Page decode; the first entry of the SLAVE_PAGE concatenation is slave 0, lowest match wins
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit_c && (bus.iomem_addr[31:24] == SLAVE_PAGE[8*(NUM_SLAVES-1-i) +: 8])) begin
                hit_c     = 1'b1;
                hit_idx_c = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_ready_c = 1'b0;
        sel_rdata_c = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready_c = bus.s_ready[i];
                sel_rdata_c = bus.s_rdata[32*i +: 32];
            end
        end
    end

`ifdef PICOSOC_IOMEM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign to_hit_c = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q != ACTIVE && state_d == ACTIVE) begin
            to_cnt_d = '0;
        end else if (state_q == ACTIVE && !sel_ready_c && !to_hit_c) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_hit_c = 1'b0;
`endif

    assign err_count_inc_c = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.iomem_valid) state_d = hit_c ? ACTIVE : RESP;
            ACTIVE:  if (sel_ready_c || to_hit_c) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of every registered output; slave ready always beats the timeout
    always_comb begin
        sel_d       = sel_q;
        s_valid_d   = '0;
        s_instr_d   = s_instr_q;
        s_wstrb_d   = s_wstrb_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: begin
                if (bus.iomem_valid) begin
                    s_instr_d = bus.iomem_instr;
                    s_wstrb_d = bus.iomem_wstrb;
                    s_addr_d  = bus.iomem_addr;
                    s_wdata_d = bus.iomem_wdata;
                    sel_d     = hit_idx_c;
                    if (hit_c) begin
                        s_valid_d[hit_idx_c] = 1'b1;
                    end else begin
                        ready_d     = 1'b1;
                        rdata_d     = ERR_RDATA;
                        err_d       = 1'b1;
                        err_code_d  = 2'b01;
                        err_addr_d  = bus.iomem_addr;
                        err_count_d = err_count_inc_c;
                    end
                end
            end
            ACTIVE: begin
                if (sel_ready_c) begin
                    ready_d = 1'b1;
                    rdata_d = sel_rdata_c;
                end else if (to_hit_c) begin
                    ready_d     = 1'b1;
                    rdata_d     = ERR_RDATA;
                    err_d       = 1'b1;
                    err_code_d  = 2'b10;
                    err_addr_d  = s_addr_q;
                    err_count_d = err_count_inc_c;
                end else begin
                    s_valid_d = s_valid_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q       <= '0;
            s_valid_q   <= '0;
            s_instr_q   <= 1'b0;
            s_wstrb_q   <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            sel_q       <= sel_d;
            s_valid_q   <= s_valid_d;
            s_instr_q   <= s_instr_d;
            s_wstrb_q   <= s_wstrb_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign bus.s_valid     = s_valid_q;
    assign bus.s_instr     = s_instr_q;
    assign bus.s_wstrb     = s_wstrb_q;
    assign bus.s_addr      = s_addr_q;
    assign bus.s_wdata     = s_wdata_q;
    assign err_o           = err_q;
    assign err_code_o      = err_code_q;
    assign err_addr_o      = err_addr_q;
    assign err_count_o     = err_count_q;

endmodule

// File: tb/tb_picosoc_iomem_router.sv
// Directed bench for picosoc_iomem_router; covers the timeout path when PICOSOC_IOMEM_TIMEOUT_EN is defined.
module tb_picosoc_iomem_router;

    localparam int unsigned NS = 8;
    // Slave 6 duplicates slave 3's page so the lowest-index rule is observable
    localparam logic [NS*8-1:0] PAGES = {8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h04, 8'h08};

    logic        clk = 1'b0;
    logic        reset;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    picosoc_iomem_router_if #(.NUM_SLAVES(NS)) bus ();

    picosoc_iomem_router #(
        .NUM_SLAVES     (NS),
        .SLAVE_PAGE     (PAGES),
        .TIMEOUT_CYCLES (15),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .err_o       (err),
        .err_code_o  (err_code),
        .err_addr_o  (err_addr),
        .err_count_o (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input logic instr);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = wstrb;
        bus.iomem_wdata = wdata;
        bus.iomem_instr = instr;
    endtask

    // Returns the cycle (counted from the request cycle 0) where iomem_ready is seen, or -1
    task automatic wait_ready(input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            tick();
            if (bus.iomem_ready === 1'b1) begin
                cyc = c;
                break;
            end
        end
        bus.iomem_valid = 1'b0;
    endtask

    int       cyc;
    logic [7:0] exp_cnt;

    initial begin
        reset           = 1'b1;
        bus.iomem_valid = 1'b0;
        bus.iomem_instr = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = '0;
        bus.iomem_wdata = '0;
        bus.s_ready     = '0;
        bus.s_rdata     = '0;
        for (int i = 0; i < NS; i++) bus.s_rdata[32*i +: 32] = 32'hA000_0000 + 32'(i);
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        check("rst_ready", 32'(bus.iomem_ready), 32'h0);
        check("rst_rdata", bus.iomem_rdata, 32'h0);
        check("rst_svalid", 32'(bus.s_valid), 32'h0);
        check("rst_saddr", bus.s_addr, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_errcnt", 32'(err_count), 32'h0);

        // Read slave 0, ready immediately
        bus.s_ready[0]       = 1'b1;
        bus.s_rdata[31:0]    = 32'h1234_5678;
        start(32'h0000_0010, 4'h0, 32'h0, 1'b1);
        tick();
        check("rd0_svalid_c1", 32'(bus.s_valid), 32'h01);
        check("rd0_sinstr_c1", 32'(bus.s_instr), 32'h1);
        check("rd0_ready_c1", 32'(bus.iomem_ready), 32'h0);
        tick();
        bus.iomem_valid = 1'b0;
        check("rd0_ready_c2", 32'(bus.iomem_ready), 32'h1);
        check("rd0_rdata_c2", bus.iomem_rdata, 32'h1234_5678);
        check("rd0_err_c2", 32'(err), 32'h0);
        tick();
        check("rd0_ready_c3", 32'(bus.iomem_ready), 32'h0);
        bus.s_ready = '0;

        // Write to slave 5, ready at cycle 3; slave 4's ready must be ignored
        start(32'h0600_0004, 4'b0011, 32'hCAFE_0001, 1'b0);
        tick();
        check("wr5_svalid_c1", 32'(bus.s_valid), 32'h20);
        check("wr5_wstrb_c1", 32'(bus.s_wstrb), 32'h3);
        check("wr5_addr_c1", bus.s_addr, 32'h0600_0004);
        check("wr5_wdata_c1", bus.s_wdata, 32'hCAFE_0001);
        bus.s_ready[4] = 1'b1;
        tick();
        check("wr5_ready_c2", 32'(bus.iomem_ready), 32'h0);
        check("wr5_addr_c2", bus.s_addr, 32'h0600_0004);
        tick();
        bus.s_ready[5] = 1'b1;
        check("wr5_ready_c3", 32'(bus.iomem_ready), 32'h0);
        check("wr5_wstrb_c3", 32'(bus.s_wstrb), 32'h3);
        check("wr5_svalid_c3", 32'(bus.s_valid), 32'h20);
        tick();
        bus.iomem_valid = 1'b0;
        bus.s_ready     = '0;
        check("wr5_ready_c4", 32'(bus.iomem_ready), 32'h1);
        check("wr5_svalid_c4", 32'(bus.s_valid), 32'h0);
        check("wr5_err_c4", 32'(err), 32'h0);
        tick();

        // Unmapped read
        start(32'h0900_0000, 4'h0, 32'h0, 1'b0);
        tick();
        bus.iomem_valid = 1'b0;
        check("um_ready_c1", 32'(bus.iomem_ready), 32'h1);
        check("um_rdata_c1", bus.iomem_rdata, 32'hDEAD_BEEF);
        check("um_err_c1", 32'(err), 32'h1);
        check("um_code_c1", 32'(err_code), 32'h1);
        check("um_addr_c1", err_addr, 32'h0900_0000);
        check("um_cnt_c1", 32'(err_count), 32'h1);
        check("um_svalid_c1", 32'(bus.s_valid), 32'h0);
        tick();
        check("um_err_c2", 32'(err), 32'h0);
        check("um_code_c2", 32'(err_code), 32'h1);
        check("um_ready_c2", 32'(bus.iomem_ready), 32'h0);

        // Duplicate page 04: slaves 3 and 6 both ready, only slave 3 selected
        bus.s_ready            = 8'h48;
        bus.s_rdata[3*32 +: 32] = 32'h3333_0003;
        bus.s_rdata[6*32 +: 32] = 32'h6666_0006;
        start(32'h0400_0100, 4'h0, 32'h0, 1'b0);
        tick();
        check("dup_svalid_c1", 32'(bus.s_valid), 32'h08);
        tick();
        bus.iomem_valid = 1'b0;
        bus.s_ready     = '0;
        check("dup_ready_c2", 32'(bus.iomem_ready), 32'h1);
        check("dup_rdata_c2", bus.iomem_rdata, 32'h3333_0003);
        tick();

        bus.s_rdata[2*32 +: 32] = 32'h2222_0002;
`ifdef PICOSOC_IOMEM_TIMEOUT_EN
        // Slave 2 never ready: abort after 15 stalled cycles
        start(32'h0300_0040, 4'h0, 32'h0, 1'b0);
        wait_ready(40, cyc);
        check("to_latency", 32'(cyc), 32'd17);
        check("to_rdata", bus.iomem_rdata, 32'hDEAD_BEEF);
        check("to_err", 32'(err), 32'h1);
        check("to_code", 32'(err_code), 32'h2);
        check("to_addr", err_addr, 32'h0300_0040);
        check("to_cnt", 32'(err_count), 32'h2);
        tick();
        // Ready arrives on the limit cycle: normal completion
        start(32'h0300_0044, 4'h0, 32'h0, 1'b0);
        for (int c = 1; c <= 16; c++) tick();
        check("tolim_ready_c16", 32'(bus.iomem_ready), 32'h0);
        bus.s_ready[2] = 1'b1;
        tick();
        bus.iomem_valid = 1'b0;
        bus.s_ready     = '0;
        check("tolim_ready_c17", 32'(bus.iomem_ready), 32'h1);
        check("tolim_rdata", bus.iomem_rdata, 32'h2222_0002);
        check("tolim_err", 32'(err), 32'h0);
        check("tolim_cnt", 32'(err_count), 32'h2);
        tick();
`else
        // Without the timeout a stalled slave is waited on; valid dropping mid-access is tolerated
        start(32'h0300_0040, 4'h0, 32'h0, 1'b0);
        wait_ready(30, cyc);
        check("stall_no_ready", 32'(cyc), 32'hFFFF_FFFF);
        check("stall_svalid", 32'(bus.s_valid), 32'h04);
        bus.s_ready[2] = 1'b1;
        wait_ready(4, cyc);
        bus.s_ready = '0;
        check("stall_latency", 32'(cyc), 32'd1);
        check("stall_rdata", bus.iomem_rdata, 32'h2222_0002);
        check("stall_err", 32'(err), 32'h0);
        check("stall_cnt", 32'(err_count), 32'h1);
        tick();
`endif

        // Reset during ACTIVE drops the transaction silently
        start(32'h0300_0000, 4'h0, 32'h0, 1'b0);
        tick();
        check("rsta_svalid_c1", 32'(bus.s_valid), 32'h04);
        reset           = 1'b1;
        bus.iomem_valid = 1'b0;
        tick();
        reset = 1'b0;
        check("rsta_svalid", 32'(bus.s_valid), 32'h0);
        check("rsta_ready", 32'(bus.iomem_ready), 32'h0);
        check("rsta_cnt", 32'(err_count), 32'h0);
        tick();
        tick();
        check("rsta_ready_after", 32'(bus.iomem_ready), 32'h0);
        check("rsta_err_after", 32'(err), 32'h0);
        bus.s_ready[0]    = 1'b1;
        bus.s_rdata[31:0] = 32'h0BAD_F00D;
        start(32'h0000_0020, 4'h0, 32'h0, 1'b0);
        wait_ready(8, cyc);
        bus.s_ready = '0;
        check("rsta_next_latency", 32'(cyc), 32'd2);
        check("rsta_next_rdata", bus.iomem_rdata, 32'h0BAD_F00D);
        tick();

        // 300 unmapped accesses saturate the error counter
        exp_cnt = 8'h00;
        for (int n = 0; n < 300; n++) begin
            start(32'hF000_0000 + 32'(n), 4'h0, 32'h0, 1'b0);
            tick();
            bus.iomem_valid = 1'b0;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            check("sat_cnt", 32'(err_count), 32'(exp_cnt));
            tick();
        end
        check("sat_final", 32'(err_count), 32'hFF);
        check("sat_addr", err_addr, 32'hF000_012B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
